// File: rtl/ext_sram_pkg.sv
// rtl/ext_sram_pkg.sv - shared types, defaults and strobe decode for ext_sram_ctrl
//
// Purpose : state and grant encodings, default widths, and the registered
//           strobe decode used by the Ram2 SRAM controller.
// Ports   : none (package).
// Config  : none here; EXT_SRAM_RDBUF_EN is consumed by ext_sram_ctrl.
package ext_sram_pkg;

  localparam int unsigned DEF_ADDR_W      = 18;
  localparam int unsigned DEF_DATA_W      = 16;
  localparam int unsigned DEF_IF_ADDR_W   = 16;
  localparam int unsigned DEF_WAIT_CYCLES = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_MEM = 1'b1
  } gnt_t;

  // Active-low SRAM strobes plus the data-bus output enable.
  typedef struct packed {
    logic en_n;
    logic oe_n;
    logic we_n;
    logic drive;
  } strobe_t;

  localparam strobe_t STROBE_IDLE = '{en_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, drive: 1'b0};

  // Strobe pattern for a given state. Called on the next state so the result
  // can be registered and appear in the same cycle as that state.
  function automatic strobe_t strobe_decode(input state_t st, input logic we);
    strobe_t s;
    s = STROBE_IDLE;
    case (st)
      IDLE: s = STROBE_IDLE;
      SETUP: begin
        s.en_n  = 1'b0;
        s.drive = we;
      end
      ACCESS: begin
        s.en_n  = 1'b0;
        s.oe_n  = we;
        s.we_n  = ~we;
        s.drive = we;
      end
      HOLD: begin
        s.en_n  = 1'b0;
        s.drive = we;
      end
      default: s = STROBE_IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ext_sram_arb.sv
// rtl/ext_sram_arb.sv - two-way round-robin arbiter between IF and MEM ports
//
// Purpose : grants one of two requesters; when both request, the one not
//           granted last time wins. After reset MEM wins the first tie.
// Ports   : clk, rst        clock, asynchronous active-high reset
//           req_if, req_mem pending requests
//           accept          grant is being consumed this cycle (updates history)
//           gnt_if, gnt_mem one-hot (or zero) combinational grant
module ext_sram_arb
  import ext_sram_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_if,
  input  logic req_mem,
  input  logic accept,
  output logic gnt_if,
  output logic gnt_mem
);

  gnt_t r_last;

  always_comb begin
    gnt_if  = 1'b0;
    gnt_mem = 1'b0;
    if (req_if && req_mem) begin
      if (r_last == GNT_MEM) gnt_if  = 1'b1;
      else                   gnt_mem = 1'b1;
    end else begin
      gnt_if  = req_if;
      gnt_mem = req_mem;
    end
  end

  // Resetting to "IF was last" makes MEM the winner of the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= GNT_IF;
    end else if (accept && (gnt_if || gnt_mem)) begin
      r_last <= gnt_mem ? GNT_MEM : GNT_IF;
    end
  end

endmodule

// File: rtl/ext_sram_ctrl.sv
// rtl/ext_sram_ctrl.sv - Ram2 asynchronous SRAM controller serving IF and MEM ports
//
// Purpose : one multi-cycle access FSM (IDLE -> SETUP -> ACCESS x WAIT_CYCLES
//           -> HOLD) shared by an IF read port and a MEM read/write port,
//           arbitrated round-robin. Strobes are registered.
// Config  : `define EXT_SRAM_RDBUF_EN adds a one-entry IF read buffer; a hit
//           is acked one cycle after the request without touching the SRAM.
// Ports   : clk, rst                 clock, asynchronous active-high reset
//           if_req_i/if_addr_i       IF read request and word address
//           if_rdata_o/if_ack_o      IF read data and one-cycle ack
//           mem_req_i/mem_we_i       MEM request and write flag
//           mem_addr_i/mem_wdata_i   MEM address and write data
//           mem_rdata_o/mem_ack_o    MEM read data and one-cycle ack
//           busy_o                   FSM not in IDLE
//           Ram2Addr_o/Ram2Data_io   SRAM address and bidirectional data
//           Ram2OE_o/WE_o/EN_o       active-low SRAM strobes
module ext_sram_ctrl
  import ext_sram_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned IF_ADDR_W   = DEF_IF_ADDR_W,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req_i,
  input  logic [IF_ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0]    if_rdata_o,
  output logic                 if_ack_o,
  input  logic                 mem_req_i,
  input  logic                 mem_we_i,
  input  logic [ADDR_W-1:0]    mem_addr_i,
  input  logic [DATA_W-1:0]    mem_wdata_i,
  output logic [DATA_W-1:0]    mem_rdata_o,
  output logic                 mem_ack_o,
  output logic                 busy_o,
  output logic [ADDR_W-1:0]    Ram2Addr_o,
  inout  wire  [DATA_W-1:0]    Ram2Data_io,
  output logic                 Ram2OE_o,
  output logic                 Ram2WE_o,
  output logic                 Ram2EN_o
);

  localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + 1);

  state_t              r_state;
  state_t              w_state_next;
  gnt_t                r_gnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [CNT_W-1:0]    r_cnt;
  strobe_t             r_strb;
  strobe_t             w_strb_next;
  logic                w_we_next;
  logic                r_if_ack;
  logic                r_mem_ack;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_mem_rdata;

  logic [ADDR_W-1:0]   w_if_addr_ext;
  logic                w_if_req_eff;
  logic                w_buf_hit;
  logic [DATA_W-1:0]   w_buf_rdata;
  logic                w_hit_serve;
  logic                w_gnt_if;
  logic                w_gnt_mem;
  logic                w_accept;
  logic                w_last_access;

  assign w_if_addr_ext = ADDR_W'(if_addr_i);

  // During the cycle a buffer-hit ack is showing, the IF requester has not
  // yet dropped its request; masking it stops a second ack for the same read.
  assign w_if_req_eff  = if_req_i & ~r_if_ack;

  assign w_last_access = (r_state == ACCESS) && (r_cnt == '0);
  assign w_hit_serve   = (r_state == IDLE) && w_buf_hit && !mem_req_i;
  assign w_accept      = (r_state == IDLE) && (w_gnt_if || w_gnt_mem);

  ext_sram_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_if  (w_if_req_eff & ~w_buf_hit),
    .req_mem (mem_req_i),
    .accept  (w_accept),
    .gnt_if  (w_gnt_if),
    .gnt_mem (w_gnt_mem)
  );

`ifdef EXT_SRAM_RDBUF_EN
  logic              r_buf_valid;
  logic [ADDR_W-1:0] r_buf_addr;
  logic [DATA_W-1:0] r_buf_data;

  assign w_buf_hit   = w_if_req_eff && r_buf_valid && (r_buf_addr == w_if_addr_ext);
  assign w_buf_rdata = r_buf_data;

  // A write is invalidating even if it targets another address: simple and
  // never stale. Writes and IF-read completions cannot coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf_valid <= 1'b0;
      r_buf_addr  <= '0;
      r_buf_data  <= '0;
    end else if (w_accept && w_gnt_mem && mem_we_i) begin
      r_buf_valid <= 1'b0;
    end else if (w_last_access && (r_gnt == GNT_IF)) begin
      r_buf_valid <= 1'b1;
      r_buf_addr  <= r_addr;
      r_buf_data  <= Ram2Data_io;
    end
  end
`else
  assign w_buf_hit   = 1'b0;
  assign w_buf_rdata = '0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_we_next    = r_we;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = SETUP;
          w_we_next    = w_gnt_mem & mem_we_i;
        end
      end
      SETUP:   w_state_next = ACCESS;
      ACCESS:  if (r_cnt == '0) w_state_next = HOLD;
      HOLD:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    w_strb_next = strobe_decode(w_state_next, w_we_next);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_strb      <= STROBE_IDLE;
      r_gnt       <= GNT_IF;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_if_ack    <= 1'b0;
      r_mem_ack   <= 1'b0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
    end else begin
      r_state <= w_state_next;
      r_strb  <= w_strb_next;
      r_we    <= w_we_next;

      if (w_accept) begin
        r_gnt   <= w_gnt_mem ? GNT_MEM : GNT_IF;
        r_addr  <= w_gnt_mem ? mem_addr_i : w_if_addr_ext;
        r_wdata <= mem_wdata_i;
      end

      if (r_state == SETUP) begin
        r_cnt <= CNT_W'(WAIT_CYCLES - 1);
      end else if ((r_state == ACCESS) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end

      // Acks are registered so they land exactly on the HOLD cycle.
      r_if_ack  <= (w_last_access && (r_gnt == GNT_IF)) || w_hit_serve;
      r_mem_ack <= w_last_access && (r_gnt == GNT_MEM);

      if (w_last_access && !r_we) begin
        if (r_gnt == GNT_IF) r_if_rdata  <= Ram2Data_io;
        else                 r_mem_rdata <= Ram2Data_io;
      end else if (w_hit_serve) begin
        r_if_rdata <= w_buf_rdata;
      end
    end
  end

  assign Ram2Data_io = r_strb.drive ? r_wdata : {DATA_W{1'bz}};
  assign Ram2Addr_o  = r_addr;
  assign Ram2EN_o    = r_strb.en_n;
  assign Ram2OE_o    = r_strb.oe_n;
  assign Ram2WE_o    = r_strb.we_n;
  assign busy_o      = (r_state != IDLE);
  assign if_ack_o    = r_if_ack;
  assign mem_ack_o   = r_mem_ack;
  assign if_rdata_o  = r_if_rdata;
  assign mem_rdata_o = r_mem_rdata;

endmodule
